// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings,
// FSM states and default latencies. The decode unit drives op with these codes.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  // Ops that occupy the unit for several cycles (and stall D-stage MD instrs).
  function automatic logic is_md_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational MULT/MULTU/DIV/DIVU datapath producing {hi,lo} plus a
// divide-by-zero flag. Non-arithmetic ops yield zero.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic [31:0] a_mag, b_mag, q_mag, r_mag;
  logic        a_neg, b_neg, sgn;

  // Signed divide goes through magnitudes so 0x80000000 / -1 wraps cleanly
  // instead of hitting the overflow corner of a native signed divide.
  always_comb begin
    sgn   = (op == MDU_DIV);
    a_neg = sgn & rs[31];
    b_neg = sgn & rt[31];
    a_mag = a_neg ? (32'd0 - rs) : rs;
    b_mag = b_neg ? (32'd0 - rt) : rt;
    if (b_mag == 32'd0) begin
      q_mag = 32'd0;
      r_mag = 32'd0;
    end else begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
  end

  // NOTE: every output gets a default before the case, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    result      = 64'd0;
    div_by_zero = 1'b0;
    case (op)
      MDU_MULT:  result = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
      MDU_MULTU: result = {32'd0, rs} * {32'd0, rt};
      MDU_DIV, MDU_DIVU: begin
        div_by_zero = (rt == 32'd0);
        result[31:0]  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        result[63:32] = a_neg ? (32'd0 - r_mag) : r_mag;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: latches the result at issue, stays busy
// for a fixed latency, then commits it to the architectural HI/LO registers.
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

  mdu_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [63:0]      pend, pend_n;
  logic             pdz, pdz_n;
  logic [31:0]      hi_q, hi_n, lo_q, lo_n;

  logic [63:0] calc_res;
  logic        calc_dz;

  mdu_calc u_calc (
    .op          (op),
    .rs          (rs),
    .rt          (rt),
    .result      (calc_res),
    .div_by_zero (calc_dz)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pend_n  = pend;
    pdz_n   = pdz;
    hi_n    = hi_q;
    lo_n    = lo_q;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (is_md_op(op)) begin
            state_n = ST_RUN;
            cnt_n   = ((op == MDU_MULT) || (op == MDU_MULTU)) ? MULT_N : DIV_N;
            pend_n  = calc_res;
            pdz_n   = calc_dz;
          end else if (op == MDU_MTHI) begin
            hi_n = rs;
          end else if (op == MDU_MTLO) begin
            lo_n = rs;
          end
        end
      end
      ST_RUN: begin
        // start is deliberately not looked at here: a request while running is dropped.
        if (cnt == CNT_W'(1)) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
          if (!pdz) begin
            hi_n = pend[63:32];
            lo_n = pend[31:0];
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      pend  <= '0;
      pdz   <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pend  <= pend_n;
      pdz   <= pdz_n;
      hi_q  <= hi_n;
      lo_q  <= lo_n;
    end
  end

  assign busy = (state == ST_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit for the 5-stage MIPS core. It sits directly downstream of the D/E pipeline register.
- Consumes the E-stage operands (E_rs, E_rt) plus a decoded op, and runs the multi-cycle MULT/MULTU/DIV/DIVU operations.
- Holds the architectural HI/LO registers and exposes busy so the hazard unit can stall D-stage MD instructions.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high for MULT/MULTU (legal range >=1).
- DIV_CYCLES, 10, cycles busy stays high for DIV/DIVU (legal range >=1).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low (rst==0 resets).
- start  input  1  one-cycle request from E stage; op/rs/rt valid this cycle.
- op  input  3  0=NONE, 1=MULT, 2=MULTU, 3=DIV, 4=DIVU, 5=MTHI, 6=MTLO; 7 is reserved and treated as NONE.
- rs  input  32  E_rs operand (dividend / multiplicand / MTHI/MTLO source).
- rt  input  32  E_rt operand (divisor / multiplier).
- busy  output  1  high while a MULT/DIV is in flight.
- hi  output  32  current HI register.
- lo  output  32  current LO register.

Behaviour:
- Reset (rst==0, async): state=IDLE, counter=0, busy=0, hi=0, lo=0, pending result=0. Reset mid-operation aborts the operation; no HI/LO update occurs afterwards.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter counts down.
- IDLE + start + op in {MULT,MULTU,DIV,DIVU}:
  - Compute the 64-bit result from rs/rt at that edge and hold it in pending {phi,plo}.
  - Load counter with MULT_CYCLES or DIV_CYCLES and go to RUN.
  - busy is high from the next cycle for exactly N cycles.
- RUN:
  - Decrement the counter each edge.
  - On the edge where the counter reaches 1: hi<=phi, lo<=plo, go to IDLE. busy falls in the same cycle HI/LO change.
  - An MFHI/MFLO issued after busy drops sees the new values.
- Arithmetic:
  - MULT: signed 32x32->64, {hi,lo}=product.
  - MULTU: unsigned.
  - DIV: lo=quotient truncated toward zero; hi=remainder, which takes the dividend's sign.
  - DIVU: unsigned quotient and remainder.
- Divide boundaries:
  - rt==0 (DIV or DIVU): still busy for DIV_CYCLES; hi/lo are left unchanged at completion.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wrap, no trap).
- MTHI/MTLO in IDLE + start: hi (resp. lo) <= rs on that edge; busy stays 0; no RUN.
- start while RUN, any op: ignored; operands not latched, HI/LO unaffected. The hazard unit guarantees this never happens; the bench checks the unit is robust.
- start with op NONE or 7: no effect.
- Hazard contract: the hazard unit stalls a D-stage MD instruction while (start & op is MULT/DIV class) | busy. The unit provides busy only.
- hi/lo outputs are straight register outputs; there is no combinational path from inputs.

Decomposition:
- Shared package mdu_pkg holds the op encodings (MDU_NONE..MDU_MTLO, 3-bit) and the default cycle counts. The decode unit uses the same constants to drive op.
- One natural sub-module: mdu_calc, purely combinational (op, rs, rt -> 64-bit result, div_by_zero flag).
- e_mdu keeps the FSM, counter, pending and HI/LO registers.

Test Plan:
- MULT rs=0xFFFFFFFE(-2), rt=0x00000003:
  - busy=1 for 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - hi/lo unchanged while busy.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF: after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=0xFFFFFFF9(-7), rt=2: busy 10 cycles, then lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1).
- DIVU rs=7, rt=0 after MTHI 0x11 and MTLO 0x22:
  - MTHI/MTLO take effect next edge with busy=0.
  - DIVU busy for 10 cycles, then hi=0x11, lo=0x22 unchanged.
- Back-to-back start:
  - MULT 3*4 issued, then DIV 9/2 start on cycle 2 while busy.
  - The DIV is ignored; final hi=0, lo=12; busy falls after exactly 5 cycles.
- Async reset mid-op:
  - Assert rst=0 between edges during cycle 3 of DIV 100/7.
  - busy/hi/lo go to 0 immediately.
  - After release with no start, hi/lo stay 0.
